lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
- Multi-cycle load/store sequencer between the ALU/control stage and the data memory.
- Takes the 3-bit memory access code from the ALU control decoder, the ALU-computed address and the store data.
- Drives a req/ack handshake to data memory, generates byte enables, replicates store data, aligns and extends load data, and stalls the core until the access completes or faults.

Parameters:
- TIMEOUT, 15: max cycles dmem_req may stay high without dmem_ack before a timeout fault (1..255).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  memory instruction present this cycle
- mem  in  3  access code: 001 byte signed, 010 half signed, 011 word, 101 byte unsigned, 110 half unsigned; 000 none; 100/111 illegal
- mem_write  in  1  1 = store, 0 = load
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  formatted load result
- misaligned  out  1  fault flag, valid with done
- timeout_err  out  1  fault flag, valid with done
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  memory read word
- dmem_ack  in  1  memory completion

Behaviour:
- Reset: state IDLE; all outputs 0 (rdata = 0); timeout counter 0.
- States: IDLE, REQ, ERR, DONE.
- IDLE:
  - If start=1 and mem=000, no action.
  - If start=1 and mem≠000, latch mem, mem_write, addr and wdata.
  - If the code is illegal or the access is misaligned, go to ERR. Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]≠0.
  - Otherwise go to REQ.
- stall (combinational): 1 when (IDLE & start & mem≠000) or state ∈ {REQ, ERR}; 0 in DONE and in idle IDLE.
- REQ:
  - dmem_req=1; dmem_we, dmem_addr, dmem_be and dmem_wdata are driven from the latched values and stay stable until ack.
  - ack sampled 1: capture the load data and go to DONE.
  - Counter increments each REQ cycle without ack; at count = TIMEOUT, go to ERR with timeout set.
- ERR: no dmem_req; next state DONE with misaligned or timeout_err set.
- DONE:
  - done=1 for exactly one cycle; go to IDLE.
  - start is ignored in DONE.
  - Fault flags are valid only while done=1 and are 0 otherwise.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load result:
  - Select the lane by addr[1:0], then sign- or zero-extend per the access code.
  - rdata updates only in DONE of a successful load and holds until the next successful load.
  - Stores and faults leave rdata unchanged.
- Minimum latency: start@T, dmem_req@T+1, ack@T+1, done@T+2. Fault latency: done@T+2.
- Ack in the same cycle as the first req is legal.
- Ack while not in REQ is ignored.
- Reset during REQ: dmem_req=0 from the next cycle; a late ack is ignored; no done pulse.
- start held high across DONE does not retrigger; it re-launches a new access only when seen in IDLE.

Test Plan:
- lw at addr 0x100, dmem_rdata=0xDEADBEEF, ack on first req cycle → dmem_be=1111, dmem_addr=0x100, done@T+2, rdata=0xDEADBEEF, stall high T..T+1.
- lb at 0x103 with rdata 0x80FF_0000, then lbu at 0x103 → dmem_be=1000; rdata=0xFFFFFF80, then 0x00000080.
- sh at 0x102, wdata=0x1234ABCD → dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD; rdata unchanged.
- lw at 0x101 → no dmem_req ever; done@T+2 with misaligned=1. Code 100 → same response.
- lw with ack held low → dmem_req high for TIMEOUT cycles, then drops; done with timeout_err=1.
- reset asserted in the second REQ cycle, ack arriving one cycle later → dmem_req=0 and stall=0 after the reset edge; no done pulse; all outputs 0.

Source files
------------

// File: rtl/lsu_controller.sv
// lsu_controller
// Multi-cycle load/store sequencer between the ALU/control stage and data
// memory. Launches one access per memory instruction, drives a req/ack
// handshake, generates byte enables and lane-replicated store data, formats
// load data (lane select plus sign/zero extension) and stalls the core until
// the access completes or faults.
//
// Ports
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   start              : memory instruction present this cycle
//   mem[2:0]           : access code (001 lb, 010 lh, 011 lw, 101 lbu, 110 lhu,
//                        000 none, 100/111 illegal)
//   mem_write          : 1 = store, 0 = load
//   addr, wdata        : byte address and store data from the pipeline
//   stall              : hold PC/pipeline
//   done               : one-cycle completion pulse
//   rdata              : formatted load result (holds until next good load)
//   misaligned,
//   timeout_err        : fault flags, only high together with done
//   dmem_req/we/addr/be/wdata : request side of the memory port
//   dmem_rdata, dmem_ack      : response side of the memory port
//
// Handshake: dmem_req rises in the first REQ cycle and the request fields stay
// stable until dmem_ack is sampled high on a rising edge; ack may come in the
// very first request cycle. An ack outside REQ is ignored.
module lsu_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mem,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        timeout_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, ERR, DONE} state_t;

  state_t      state;
  logic [2:0]  mem_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt;
  logic        fault_to;   // 1 = fault in ERR came from timeout, 0 = misaligned/illegal

  logic        launch;
  logic        illegal;
  logic        mis;
  logic        in_req;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [31:0] lane;
  logic        sx;
  logic [31:0] load_fmt;

  assign launch  = start && (mem != 3'b000);
  assign illegal = (mem == 3'b100) || (mem == 3'b111);
  assign mis     = ((mem[1:0] == 2'b10) && addr[0]) ||
                   ((mem[1:0] == 2'b11) && (addr[1:0] != 2'b00));
  assign in_req  = (state == REQ);

  assign stall = (state == IDLE && launch) || (state == REQ) || (state == ERR);

  // Size comes from mem_q[1:0]; mem_q[2] only selects zero extension.
  always_comb begin
    be_calc = 4'b1111;
    wd_calc = wdata_q;
    case (mem_q[1:0])
      2'b01: begin
        be_calc = 4'b0001 << addr_q[1:0];
        wd_calc = {4{wdata_q[7:0]}};
      end
      2'b10: begin
        be_calc = 4'b0011 << addr_q[1:0];
        wd_calc = {2{wdata_q[15:0]}};
      end
      default: begin
        be_calc = 4'b1111;
        wd_calc = wdata_q;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend.
  assign lane = dmem_rdata >> {addr_q[1:0], 3'b000};
  assign sx   = ~mem_q[2];

  always_comb begin
    load_fmt = lane;
    case (mem_q[1:0])
      2'b01:   load_fmt = {{24{sx & lane[7]}}, lane[7:0]};
      2'b10:   load_fmt = {{16{sx & lane[15]}}, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  // Request fields are forced to zero outside REQ so the bus is quiet when idle.
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & we_q;
  assign dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_be    = in_req ? be_calc : 4'h0;
  assign dmem_wdata = in_req ? wd_calc : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_q       <= 3'b000;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cnt         <= 8'h0;
      fault_to    <= 1'b0;
      done        <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      rdata       <= 32'h0;
    end else begin
      done        <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            mem_q    <= mem;
            we_q     <= mem_write;
            addr_q   <= addr;
            wdata_q  <= wdata;
            cnt      <= 8'h0;
            fault_to <= 1'b0;
            state    <= (illegal || mis) ? ERR : REQ;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            if (!we_q) rdata <= load_fmt;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
            // This cycle is the TIMEOUT-th without ack: give up.
            if (cnt == 8'(TIMEOUT - 1)) begin
              fault_to <= 1'b1;
              state    <= ERR;
            end
          end
        end
        ERR: begin
          done        <= 1'b1;
          misaligned  <= ~fault_to;
          timeout_err <= fault_to;
          state       <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed cases plus randomized
// accesses scored against an arithmetic model of the access rules.
module tb_lsu_controller;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mem;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        timeout_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int vectors;
  int miscompares;
  logic [31:0] model_rdata;
  logic [31:0] exp_q[$];

  lsu_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .mem(mem), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misaligned(misaligned), .timeout_err(timeout_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int size_of(input logic [2:0] m);
    case (m[1:0])
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_fault(input logic [2:0] m, input logic [31:0] a);
    if (m == 3'd4 || m == 3'd7) return 1'b1;
    return (a % size_of(m)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] m, input logic [31:0] a);
    int sz;
    sz = size_of(m);
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] m, input logic [31:0] wd);
    case (size_of(m))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] m, input logic [31:0] a,
                                             input logic [31:0] word);
    longint v;
    longint span;
    int sz;
    sz = size_of(m);
    if (sz == 4) return word;
    span = longint'(1) << (8 * sz);
    v = (longint'(word) >> (8 * (a % 4))) % span;
    if (m[2] == 1'b0 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // driver: one access from launch through the cycle after done
  task automatic run_txn(input logic [2:0] m, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_at, input bit hold);
    bit fault;
    bit acked;
    bit tmo;
    logic [31:0] e_rd;
    fault = is_fault(m, a);
    tmo   = !fault && ack_at >= TIMEOUT;
    if (!fault && !tmo && !w) exp_q.push_back(model_load(m, a, rd));
    else exp_q.push_back(model_rdata);

    @(negedge clk);
    start = 1'b1; mem = m; mem_write = w; addr = a; wdata = wd; dmem_ack = 1'b0;
    #1 check("stall_launch", stall, 1);
    @(negedge clk);
    if (!hold) begin
      start = 1'b0; mem = 3'($urandom); mem_write = 1'($urandom);
      addr = $urandom; wdata = $urandom;
    end
    acked = 1'b0;
    if (!fault) begin
      for (int k = 0; k < TIMEOUT && !acked; k++) begin
        check("req", dmem_req, 1);
        check("we", dmem_we, w);
        check("daddr", dmem_addr, {a[31:2], 2'b00});
        check("be", dmem_be, model_be(m, a));
        if (w) check("dwdata", dmem_wdata, model_wd(m, wd));
        check("stall_req", stall, 1);
        check("done_req", done, 0);
        dmem_ack   = (k == ack_at);
        dmem_rdata = (k == ack_at) ? rd : $urandom;
        acked      = (k == ack_at);
        @(negedge clk);
        dmem_ack = 1'b0;
      end
    end
    if (!acked) begin
      check("req_err", dmem_req, 0);
      check("stall_err", stall, 1);
      check("done_err", done, 0);
      @(negedge clk);
    end
    // done cycle
    e_rd = exp_q.pop_front();
    model_rdata = e_rd;
    check("done", done, 1);
    check("misaligned", misaligned, fault);
    check("timeout_err", timeout_err, tmo);
    check("rdata", rdata, e_rd);
    check("stall_done", stall, 0);
    check("req_done", dmem_req, 0);
    start = 1'b0;
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    @(negedge clk);
    check("done_after", done, 0);
    check("flags_after", {misaligned, timeout_err}, 0);
    check("stall_after", stall, 0);
    check("req_after", dmem_req, 0);
    check("rdata_hold", rdata, model_rdata);
    dmem_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_flags"}, {misaligned, timeout_err}, 0);
    check({tag, "_req"}, {dmem_req, dmem_we, dmem_be}, 0);
    check({tag, "_daddr"}, dmem_addr, 0);
    check({tag, "_dwdata"}, dmem_wdata, 0);
  endtask

  task automatic reset_in_req();
    @(negedge clk);
    start = 1'b1; mem = 3'b011; mem_write = 1'b0; addr = 32'h200; dmem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("rst_req1", dmem_req, 1);
    @(negedge clk);
    check("rst_req2", dmem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rst_late_done", done, 0);
    check("rst_late_req", dmem_req, 0);
    check("rst_late_rdata", rdata, 0);
    dmem_ack = 1'b0;
    model_rdata = 32'h0;
  endtask

  initial begin
    logic [2:0] codes[7];
    vectors = 0; miscompares = 0; model_rdata = 32'h0;
    codes = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd4, 3'd7};
    reset = 1'b1; start = 1'b0; mem = 3'b0; mem_write = 1'b0; addr = 32'h0;
    wdata = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // directed cases
    run_txn(3'b011, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    run_txn(3'b001, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0);
    run_txn(3'b101, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 2, 1'b0);
    run_txn(3'b010, 1'b1, 32'h102, 32'h1234_ABCD, 32'h0, 1, 1'b0);
    run_txn(3'b011, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    run_txn(3'b100, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    run_txn(3'b011, 1'b0, 32'h104, 32'h0, 32'h1111_2222, NEVER, 1'b0);
    run_txn(3'b110, 1'b0, 32'h10A, 32'h0, 32'h8765_4321, 0, 1'b1);

    // start with code 000 does nothing
    @(negedge clk);
    start = 1'b1; mem = 3'b000;
    #1 check("nop_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    check("nop_req", dmem_req, 0);
    check("nop_stall2", stall, 0);
    @(negedge clk);
    check("nop_done", done, 0);

    reset_in_req();

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [2:0] m;
      int ack_at;
      m = ($urandom_range(0, 9) == 0) ? codes[$urandom_range(5, 6)] : codes[$urandom_range(0, 4)];
      ack_at = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 4);
      run_txn(m, 1'($urandom), 32'h1000 + 32'($urandom_range(0, 63)), $urandom, $urandom,
              ack_at, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        dmem_ack = 1'($urandom);
        #1 check("idle_req", dmem_req, 0);
      end
      dmem_ack = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
